// File: rtl/rst_ctrl_pkg.sv
// Shared types and helpers for the reset sequencer: reset-cause and state
// encodings, counter sizing, and cause priority.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_POR = 2'd0,
    RST_PLL = 2'd1,
    RST_BTN = 2'd2,
    RST_SW  = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_e;

  // Width that holds 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  // Lost lock outranks the button, which outranks a software request.
  function automatic rst_cause_e reset_cause(input logic lock_lost,
                                             input logic btn,
                                             input logic sw);
    if (lock_lost)  return RST_PLL;
    else if (btn)   return RST_BTN;
    else if (sw)    return RST_SW;
    else            return RST_POR;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Multi-flop synchroniser with an optional stable-level debouncer.
// DebounceCycles == 0 passes the synchronised level straight through.
module rst_debounce
  import rst_ctrl_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_btn_i,
  output logic btn_db
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  btn_sync;

  assign sync_d   = {sync_q[SyncStages-2:0], rst_btn_i};
  assign btn_sync = sync_q[SyncStages-1];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  if (DebounceCycles == 0) begin : g_bypass
    assign btn_db = btn_sync;
  end else begin : g_debounce
    localparam int unsigned CntW = cnt_width(DebounceCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            db_q, db_d;

    always_comb begin
      // NOTE: every output gets a default first, so no path infers a latch.
      cnt_d = '0;
      db_d  = db_q;
      if (btn_sync != db_q) begin
        if (cnt_q == CntW'(DebounceCycles - 1)) db_d  = btn_sync;
        else                                    cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        db_q  <= db_d;
      end
    end

    assign btn_db = db_q;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges PLL lock, debounced button and software request,
// holds reset, then releases the domains one at a time in index order.
module rst_seq_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int unsigned NumDomains     = 3,
  parameter int unsigned HoldCycles     = 256,
  parameter int unsigned ReleaseGap     = 16,
  parameter int unsigned DebounceCycles = 1000,
  parameter int unsigned SyncStages     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  rst_btn_i,
  input  logic                  sw_rst_req_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  rst_done_o,
  output logic [1:0]            rst_cause_o
);

  localparam int unsigned HoldW = cnt_width(HoldCycles - 1);
  localparam int unsigned GapW  = cnt_width(ReleaseGap - 1);
  localparam int unsigned IdxW  = cnt_width(NumDomains - 1);

  logic lock_sync, btn_db, req;

  rst_debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (0)
  ) u_lock_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rst_btn_i (pll_locked_i),
    .btn_db    (lock_sync)
  );

  rst_debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) u_btn_debounce (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rst_btn_i (rst_btn_i),
    .btn_db    (btn_db)
  );

  assign req = ~lock_sync | btn_db | sw_rst_req_i;

  rst_state_e            state_q, state_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  rst_cause_e            cause_q, cause_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    cause_d = cause_q;

    if (req && state_q != ST_ASSERT) begin
      // Any source re-asserts every domain at once and records why.
      state_d = ST_ASSERT;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
      cause_d = reset_cause(~lock_sync, btn_db, sw_rst_req_i);
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          rst_n_d = '0;
          done_d  = 1'b0;
          if (req) begin
            hold_d = '0;
          end else if (hold_q == HoldW'(HoldCycles - 1)) begin
            hold_d     = '0;
            gap_d      = '0;
            idx_d      = IdxW'(1);
            rst_n_d[0] = 1'b1;
            if (NumDomains == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_q == GapW'(ReleaseGap - 1)) begin
            gap_d          = '0;
            rst_n_d[idx_q] = 1'b1;
            if (idx_q == IdxW'(NumDomains - 1)) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_RUN: ;
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= RST_POR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_no      = rst_n_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule
